// File: rtl/hexparse_pkg.sv
// hexparse_pkg: shared state encoding and terminator characters for the hex parser.
package hexparse_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_ERR, ST_EMIT} t_hexparse_state;
    localparam logic [7:0] CHAR_CR    = 8'h0d;
    localparam logic [7:0] CHAR_LF    = 8'h0a;
    localparam logic [7:0] CHAR_SPACE = 8'h20;
endpackage

// File: rtl/hexparse_hexnibble.sv
// hexnibble: decodes one ASCII hex character (either case) into its nibble value.
module hexnibble #(
    parameter int CHAR_SIZE  = 8,
    parameter int DIGIT_SIZE = 4
) (
    input  logic [CHAR_SIZE-1:0]  in_char,
    output logic [DIGIT_SIZE-1:0] out_digit,
    output logic                  out_is_digit
);
    logic is_num, is_lo, is_up;
    logic [3:0] low;
    // full-width compares so any set upper bit rejects the char
    always_comb begin
        is_num       = in_char >= CHAR_SIZE'(8'h30) && in_char <= CHAR_SIZE'(8'h39);
        is_lo        = in_char >= CHAR_SIZE'(8'h61) && in_char <= CHAR_SIZE'(8'h66);
        is_up        = in_char >= CHAR_SIZE'(8'h41) && in_char <= CHAR_SIZE'(8'h46);
        low          = in_char[3:0];
        out_is_digit = is_num || is_lo || is_up;
        out_digit    = DIGIT_SIZE'(is_num ? low : low + 4'd9);
    end
endmodule

// File: rtl/hexparse.sv
// hexparse: turns terminator-delimited ASCII hex tokens into binary values,
// strobing out_valid for good tokens and out_err for malformed or overlong ones.
module hexparse
    import hexparse_pkg::*;
#(
    parameter int NUM_CHARS  = 2,
    parameter int CHAR_SIZE  = 8,
    parameter int DIGIT_SIZE = 4
) (
    input  logic                             in_clk,
    input  logic                             in_rst,
    input  logic [CHAR_SIZE-1:0]             in_char,
    input  logic                             in_char_valid,
    output logic                             out_ready,
    output logic [DIGIT_SIZE*NUM_CHARS-1:0]  out_value,
    output logic                             out_valid,
    output logic                             out_err,
    output logic [$clog2(NUM_CHARS+1)-1:0]   out_digits
);
    localparam int VW = DIGIT_SIZE * NUM_CHARS;
    localparam int CW = $clog2(NUM_CHARS + 1);

    t_hexparse_state state, nxt;
    logic [VW-1:0] acc;
    logic [CW-1:0] cnt;
    logic [DIGIT_SIZE-1:0] nibble;
    logic is_digit, is_term, take, full;

    hexnibble #(.CHAR_SIZE(CHAR_SIZE), .DIGIT_SIZE(DIGIT_SIZE)) u_nib (
        .in_char     (in_char),
        .out_digit   (nibble),
        .out_is_digit(is_digit)
    );

    assign is_term = in_char == CHAR_SIZE'(CHAR_CR) || in_char == CHAR_SIZE'(CHAR_LF) ||
                     in_char == CHAR_SIZE'(CHAR_SPACE);
    assign take = in_char_valid && out_ready;
    assign full = cnt == CW'(NUM_CHARS);

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) state <= ST_IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:  if (take) nxt = is_digit ? ST_ACCUM : is_term ? ST_IDLE : ST_ERR;
            ST_ACCUM: if (take) nxt = is_term ? ST_EMIT : (is_digit && !full) ? ST_ACCUM : ST_ERR;
            ST_ERR:   if (take && is_term) nxt = ST_IDLE;
            default:  nxt = ST_IDLE;
        endcase
    end

    always_comb out_ready = state != ST_EMIT;

    // acc is only cleared on leaving ST_ERR/ST_EMIT; ST_IDLE always starts a token fresh
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            acc        <= '0;
            cnt        <= '0;
            out_value  <= '0;
            out_digits <= '0;
            out_valid  <= 1'b0;
            out_err    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            if (state == ST_EMIT) begin
                acc <= '0;
                cnt <= '0;
            end else if (take) begin
                if (state == ST_IDLE && is_digit) begin
                    acc <= VW'(nibble);
                    cnt <= CW'(1);
                end else if (state == ST_ACCUM && is_digit && !full) begin
                    acc <= (acc << DIGIT_SIZE) | VW'(nibble);
                    cnt <= cnt + CW'(1);
                end else if (state == ST_ACCUM && is_term) begin
                    out_value  <= acc;
                    out_digits <= cnt;
                    out_valid  <= 1'b1;
                end else if (state == ST_ERR && is_term) begin
                    out_err <= 1'b1;
                    acc     <= '0;
                    cnt     <= '0;
                end
            end
        end
    end
endmodule
